// File: rtl/vitenc_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// vitenc_frame_ctrl_if
// Bit-source handshake between the information-bit source and the frame
// sequencer.
//   start     : source -> ctrl, request one frame (honoured only while idle)
//   bit_in    : source -> ctrl, information bit
//   bit_valid : source -> ctrl, bit_in is valid
//   bit_ready : ctrl -> source, bit accepted when bit_valid && bit_ready
// Modports: master = bit source, slave = frame controller.
// ---------------------------------------------------------------------------
interface vitenc_frame_ctrl_if;
  logic start;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output start,
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  start,
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/vitenc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vitenc_frame_ctrl
// Frame sequencer for the rate-1/2, K=3 (7/5) convolutional encoder. It takes
// FRAME_LEN information bits over a valid/ready handshake, appends TAIL_LEN
// zero tail bits that return the trellis to state 00, and marks which encoder
// output symbols belong to the frame.
//
// Ports:
//   i_clk           : clock, all registers update on the rising edge
//   i_rst_n         : synchronous active-low reset
//   s_bus           : bit-source handshake (slave modport)
//   o_enc_datain    : registered bit for the encoder datain
//   o_enc_sym_valid : registered, high while the encoder output holds a
//                     frame symbol
//   o_frame_done    : one-cycle pulse at the end of each frame
//   o_frame_err     : one-cycle pulse with o_frame_done on an aborted frame
//   o_busy          : controller is not idle
//
// Optional feature: define VITENC_CTRL_PARITY_EN to send an even-parity bit
// (XOR of all data bits) between the data bits and the tail.
// ---------------------------------------------------------------------------
module vitenc_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  vitenc_frame_ctrl_if.slave  s_bus,
  output logic                o_enc_datain,
  output logic                o_enc_sym_valid,
  output logic                o_frame_done,
  output logic                o_frame_err,
  output logic                o_busy
);

  localparam int               CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_LEN - 1);
  // FLUSH and TAIL both last two cycles and share the 1-bit phase counter.
  localparam logic [0:0]       LAST_TAIL  = 1'(TAIL_LEN - 1);
  localparam logic [0:0]       LAST_FLUSH = 1'b1;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DATA   = 3'd2,
    ST_TAIL   = 3'd3,
`ifdef VITENC_CTRL_PARITY_EN
    ST_ABORT  = 3'd4,
    ST_PARITY = 3'd5
`else
    ST_ABORT  = 3'd4
`endif
  } state_t;

  state_t           r_state;
  logic [0:0]       r_ph;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_datain;
  logic             r_mark;
  logic             r_sym_valid;
  logic             r_done_pend;
  logic             r_err_pend;
  logic             r_done;
  logic             r_err;
  logic             w_bit_ready;
`ifdef VITENC_CTRL_PARITY_EN
  logic             r_par;

  // Even-parity accumulator step.
  function automatic logic f_par_acc(input logic acc, input logic b);
    return acc ^ b;
  endfunction
`endif

  assign w_bit_ready     = (r_state == ST_DATA);
  assign s_bus.bit_ready = w_bit_ready;
  assign o_enc_datain    = r_datain;
  assign o_enc_sym_valid = r_sym_valid;
  assign o_frame_done    = r_done;
  assign o_frame_err     = r_err;
  assign o_busy          = (r_state != ST_IDLE);

  // Frame sequencing FSM with its registered encoder-side outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_FLUSH;
      r_ph        <= 1'b0;
      r_bit_cnt   <= '0;
      r_datain    <= 1'b0;
      r_mark      <= 1'b0;
      r_sym_valid <= 1'b0;
      r_done_pend <= 1'b0;
      r_err_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef VITENC_CTRL_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      // The encoder output lags datain by one edge; mark is delayed to match.
      r_sym_valid <= r_mark;
      // End-of-frame is flagged one edge after the last drive, which is when
      // the encoder presents that last symbol.
      r_done      <= r_done_pend;
      r_err       <= r_err_pend;
      r_done_pend <= 1'b0;
      r_err_pend  <= 1'b0;
      // The encoder samples every edge, so a defined 0 is the idle drive.
      r_datain    <= 1'b0;
      r_mark      <= 1'b0;
      case (r_state)
        ST_FLUSH: begin
          if (r_ph == LAST_FLUSH) begin
            r_state <= ST_IDLE;
            r_ph    <= 1'b0;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_IDLE: begin
          if (s_bus.start) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
`ifdef VITENC_CTRL_PARITY_EN
            r_par     <= 1'b0;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (s_bus.bit_valid) begin
            r_datain  <= s_bus.bit_in;
            r_mark    <= 1'b1;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef VITENC_CTRL_PARITY_EN
            r_par     <= f_par_acc(r_par, s_bus.bit_in);
`endif
            if (r_bit_cnt == LAST_BIT) begin
`ifdef VITENC_CTRL_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_TAIL;
`endif
              r_ph    <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            // Underrun: the zero driven here is the first of two that flush
            // the encoder; ABORT drives the second.
            r_state <= ST_ABORT;
          end
        end
`ifdef VITENC_CTRL_PARITY_EN
        ST_PARITY: begin
          r_datain <= r_par;
          r_mark   <= 1'b1;
          r_state  <= ST_TAIL;
          r_ph     <= 1'b0;
        end
`endif
        ST_TAIL: begin
          r_mark <= 1'b1;
          if (r_ph == LAST_TAIL) begin
            r_state     <= ST_IDLE;
            r_ph        <= 1'b0;
            r_done_pend <= 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_ABORT: begin
          r_state     <= ST_IDLE;
          r_done_pend <= 1'b1;
          r_err_pend  <= 1'b1;
        end
        default: begin
          r_state <= ST_FLUSH;
          r_ph    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vitenc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vitenc_frame_ctrl
// Self-checking bench for vitenc_frame_ctrl. Two instances: FRAME_LEN=4 (A)
// and FRAME_LEN=1 (B). Each drives a behavioural 7/5 K=3 encoder; frame
// symbols are collected while enc_sym_valid is high and compared against
// hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_vitenc_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vitenc_frame_ctrl_if bus_a ();
  vitenc_frame_ctrl_if bus_b ();

  logic enc_datain [2];
  logic sym_valid  [2];
  logic done       [2];
  logic err        [2];
  logic busy       [2];

  vitenc_frame_ctrl #(.FRAME_LEN(4), .TAIL_LEN(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_a.slave),
    .o_enc_datain(enc_datain[0]), .o_enc_sym_valid(sym_valid[0]),
    .o_frame_done(done[0]), .o_frame_err(err[0]), .o_busy(busy[0])
  );

  vitenc_frame_ctrl #(.FRAME_LEN(1), .TAIL_LEN(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_b.slave),
    .o_enc_datain(enc_datain[1]), .o_enc_sym_valid(sym_valid[1]),
    .o_frame_done(done[1]), .o_frame_err(err[1]), .o_busy(busy[1])
  );

  // Expected symbol sequences, first symbol in the most significant pair.
`ifdef VITENC_CTRL_PARITY_EN
  localparam logic [63:0] EXP_A_SYM = 64'h0000_0000_0000_3867; // 11,10,00,01,10,01,11
  localparam int          EXP_A_CNT = 7;
  localparam logic [63:0] EXP_B_SYM = 64'h0000_0000_0000_00D7; // 11,01,01,11
  localparam int          EXP_B_CNT = 4;
`else
  localparam logic [63:0] EXP_A_SYM = 64'h0000_0000_0000_0E17; // 11,10,00,01,01,11
  localparam int          EXP_A_CNT = 6;
  localparam logic [63:0] EXP_B_SYM = 64'h0000_0000_0000_003B; // 11,10,11
  localparam int          EXP_B_CNT = 3;
`endif
  localparam logic [63:0] EXP_ABORT_SYM = 64'h0000_0000_0000_000E; // 11,10
  localparam logic [3:0]  BITS_1011     = 4'b1101;                 // bit0 sent first

  // Behavioural encoder (starts in a non-zero state to exercise the flush).
  logic [1:0] enc_sreg [2] = '{2'b11, 2'b10};
  logic [1:0] vitenc   [2] = '{2'b00, 2'b00};
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      vitenc[k]   <= {enc_datain[k] ^ enc_sreg[k][1] ^ enc_sreg[k][0],
                      enc_datain[k] ^ enc_sreg[k][0]};
      enc_sreg[k] <= {enc_datain[k], enc_sreg[k][1]};
    end
  end

  // Output collector; counters only grow, tasks work on deltas.
  logic [63:0] sym_pack   [2] = '{64'd0, 64'd0};
  int          sym_cnt    [2] = '{0, 0};
  int          done_cnt   [2] = '{0, 0};
  int          err_cnt    [2] = '{0, 0};
  int          done_cyc   [2] = '{0, 0};
  int          err_cyc    [2] = '{0, 0};
  int          last_v_cyc [2] = '{0, 0};
  int          rises      [2] = '{0, 0};
  logic        prev_v     [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (sym_valid[k] === 1'b1) begin
        sym_pack[k]   = {sym_pack[k][61:0], vitenc[k]};
        sym_cnt[k]    = sym_cnt[k] + 1;
        last_v_cyc[k] = cyc;
        if (!prev_v[k]) rises[k] = rises[k] + 1;
      end
      if (done[k] === 1'b1) begin
        done_cnt[k] = done_cnt[k] + 1;
        done_cyc[k] = cyc;
      end
      if (err[k] === 1'b1) begin
        err_cnt[k] = err_cnt[k] + 1;
        err_cyc[k] = cyc;
      end
      prev_v[k] = (sym_valid[k] === 1'b1);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input int k, input logic st, input logic v, input logic b);
    if (k == 0) begin
      bus_a.start = st; bus_a.bit_valid = v; bus_a.bit_in = b;
    end else begin
      bus_b.start = st; bus_b.bit_valid = v; bus_b.bit_in = b;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? bus_a.bit_ready : bus_b.bit_ready;
  endfunction

  // One frame on instance k; stall_at >= 0 drops bit_valid at that bit index,
  // noise keeps start high through DATA and both TAIL edges.
  task automatic run_frame(input int k, input int n, input logic [3:0] bits,
                           input int stall_at, input logic noise,
                           input logic [63:0] exp_sym, input int exp_cnt,
                           input string tag);
    int          b_sym, b_done, b_err, b_rise, stall_cyc, t;
    logic [63:0] mask;
    b_sym = sym_cnt[k]; b_done = done_cnt[k]; b_err = err_cnt[k]; b_rise = rises[k];
    stall_cyc = -1;
    drive(k, 1'b1, 1'b0, 1'b0);
    tick();
    check_val({tag, ".ready"}, 64'(rdy(k)), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        drive(k, 1'b0, 1'b0, 1'b0);
        tick();
        stall_cyc = cyc;
        break;
      end
      drive(k, noise, 1'b1, bits[i]);
      tick();
    end
    drive(k, noise, 1'b0, 1'b0);
    tick();
    tick();
    drive(k, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (done_cnt[k] == b_done && t < 20) begin
      tick();
      t = t + 1;
    end
    mask = (64'd1 << (2 * exp_cnt)) - 64'd1;
    check_val({tag, ".done_cnt"}, 64'(done_cnt[k] - b_done), 64'd1);
    check_val({tag, ".sym_cnt"}, 64'(sym_cnt[k] - b_sym), 64'(exp_cnt));
    check_val({tag, ".symbols"}, sym_pack[k] & mask, exp_sym);
    check_val({tag, ".contig"}, 64'(rises[k] - b_rise), 64'd1);
    if (stall_at >= 0) begin
      check_val({tag, ".err_cnt"}, 64'(err_cnt[k] - b_err), 64'd1);
      check_val({tag, ".done_lat"}, 64'(done_cyc[k]), 64'(stall_cyc + 2));
      check_val({tag, ".err_with_done"}, 64'(err_cyc[k]), 64'(done_cyc[k]));
    end else begin
      check_val({tag, ".err_cnt"}, 64'(err_cnt[k] - b_err), 64'd0);
      check_val({tag, ".done_at_last_sym"}, 64'(done_cyc[k]), 64'(last_v_cyc[k]));
    end
    tick();
    tick();
    check_val({tag, ".idle_after"}, 64'(busy[k]), 64'd0);
    check_val({tag, ".no_extra_done"}, 64'(done_cnt[k] - b_done), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".datain"}, 64'(enc_datain[0]), 64'd0);
    check_val({tag, ".sym_valid"}, 64'(sym_valid[0]), 64'd0);
    check_val({tag, ".done"}, 64'(done[0]), 64'd0);
    check_val({tag, ".err"}, 64'(err[0]), 64'd0);
    check_val({tag, ".ready"}, 64'(bus_a.bit_ready), 64'd0);
    check_val({tag, ".busy"}, 64'(busy[0]), 64'd1);
  endtask

  // Hard stop in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_err, b_sym;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0);  // start during FLUSH must be ignored
    tick();
    check_val("por.flush1_busy", 64'(busy[0]), 64'd1);
    drive(0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("por.flush2_done", 64'(busy[0]), 64'd0);

    run_frame(0, 4, BITS_1011, -1, 1'b0, EXP_A_SYM, EXP_A_CNT, "frame1");
    run_frame(0, 4, BITS_1011, 2, 1'b0, EXP_ABORT_SYM, 2, "abort");
    run_frame(0, 4, BITS_1011, -1, 1'b0, EXP_A_SYM, EXP_A_CNT, "after_abort");
    run_frame(0, 4, BITS_1011, -1, 1'b1, EXP_A_SYM, EXP_A_CNT, "start_noise");

    // start held high: two back-to-back frames with a single IDLE cycle.
    b_done = done_cnt[0];
    b_sym  = sym_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive(0, 1'b1, 1'b1, BITS_1011[i]);
        tick();
      end
      drive(0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check_val("b2b.idle_gap", 64'(busy[0]), 64'd0);
      if (f == 0) begin
        tick();
        check_val("b2b.restart_ready", 64'(bus_a.bit_ready), 64'd1);
      end else begin
        drive(0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("b2b.stays_idle", 64'(busy[0]), 64'd0);
      end
    end
    tick();
    tick();
    check_val("b2b.done_cnt", 64'(done_cnt[0] - b_done), 64'd2);
    check_val("b2b.sym_cnt", 64'(sym_cnt[0] - b_sym), 64'(2 * EXP_A_CNT));

    // Reset pulse in the middle of DATA.
    b_done = done_cnt[0];
    b_err  = err_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1);
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("midrst.flush1_busy", 64'(busy[0]), 64'd1);
    tick();
    check_val("midrst.idle", 64'(busy[0]), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check_val("midrst.no_done", 64'(done_cnt[0] - b_done), 64'd0);
    check_val("midrst.no_err", 64'(err_cnt[0] - b_err), 64'd0);
    run_frame(0, 4, BITS_1011, -1, 1'b0, EXP_A_SYM, EXP_A_CNT, "post_rst");

    // FRAME_LEN=1 instance.
    run_frame(1, 1, 4'b0001, -1, 1'b0, EXP_B_SYM, EXP_B_CNT, "len1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
